// File: rtl/conv_window_gen.sv
// 3x3 sliding-window generator: two line buffers plus a 3x3 shift register turn a
// raster pixel stream into one complete (unpadded) neighbourhood per output beat.
module conv_window_gen #(
    parameter int IMG_W = 256,
    parameter int IMG_H = 256,
    parameter int PIX_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               go,
    input  logic [PIX_W-1:0]   pix_in,
    input  logic               pix_valid,
    output logic               pix_ready,
    output logic [9*PIX_W-1:0] win_out,
    output logic               win_valid,
    input  logic               win_ready,
    output logic               busy,
    output logic               done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    col;
    logic [RW-1:0]    row;

    // lb1 holds row y-2, lb0 holds row y-1, both indexed by column.
    logic [PIX_W-1:0] lb0 [IMG_W];
    logic [PIX_W-1:0] lb1 [IMG_W];

    logic             pix_acc;
    logic             last_col;
    logic             last_row;
    logic             win_hs;
    logic [9*PIX_W-1:0] win_shift;

    assign pix_ready = (state == RUN) && (!win_valid || win_ready);
    assign pix_acc   = pix_valid && pix_ready;
    assign win_hs    = win_valid && win_ready;
    assign last_col  = (col == CW'(IMG_W - 1));
    assign last_row  = (row == RW'(IMG_H - 1));

    // Window shifted left one column, new right column = {row y-2, row y-1, current}.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        win_shift = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 2; c++) begin
                win_shift[PIX_W*(3*r+c) +: PIX_W] = win_out[PIX_W*(3*r+c+1) +: PIX_W];
            end
        end
        win_shift[PIX_W*2 +: PIX_W] = lb1[col];
        win_shift[PIX_W*5 +: PIX_W] = lb0[col];
        win_shift[PIX_W*8 +: PIX_W] = pix_in;
    end

    // NOTE: line-buffer RAM has no reset; stale contents are never emitted because
    // windows are only flagged valid once two full rows have been written.
    always_ff @(posedge clk) begin
        if (pix_acc) begin
            lb1[col] <= lb0[col];
            lb0[col] <= pix_in;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees
    // the pre-edge value of every other register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            col       <= '0;
            row       <= '0;
            win_out   <= '0;
            win_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        state <= RUN;
                        col   <= '0;
                        row   <= '0;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (pix_acc) begin
                        win_out   <= win_shift;
                        // Any current window is being handed off here, so load or clear.
                        win_valid <= (row >= RW'(2)) && (col >= CW'(2));
                        if (last_col) begin
                            col <= '0;
                            if (last_row) begin
                                row   <= '0;
                                state <= DRAIN;
                            end else begin
                                row <= row + RW'(1);
                            end
                        end else begin
                            col <= col + CW'(1);
                        end
                    end else if (win_hs) begin
                        win_valid <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (win_hs) begin
                        win_valid <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_window_gen.sv
// Scoreboard bench for conv_window_gen: 4x4 instance with queued expected windows,
// plus a 5x3 instance checked cycle by cycle for latency and throughput.
module tb_conv_window_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        go, pix_valid, pix_ready, win_valid, win_ready, busy, done;
    logic [7:0]  pix_in;
    logic [71:0] win_out;

    logic        go5, pv5, pr5, wv5, busy5, done5;
    logic [7:0]  pix5;
    logic [71:0] w5;

    always #5 clk = ~clk;

    conv_window_gen #(.IMG_W(4), .IMG_H(4), .PIX_W(8)) u_dut (
        .clk(clk), .rst(rst), .go(go), .pix_in(pix_in), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .win_out(win_out), .win_valid(win_valid),
        .win_ready(win_ready), .busy(busy), .done(done)
    );

    conv_window_gen #(.IMG_W(5), .IMG_H(3), .PIX_W(8)) u_dut5 (
        .clk(clk), .rst(rst), .go(go5), .pix_in(pix5), .pix_valid(pv5),
        .pix_ready(pr5), .win_out(w5), .win_valid(wv5),
        .win_ready(1'b1), .busy(busy5), .done(done5)
    );

    int errors = 0;
    int checks = 0;

    logic [71:0] sb [$];
    logic [7:0]  pix_mem [64];

    int wr_mode    = 0;   // 0: always ready, 1: stall first window, 2: random
    int stall_left = 0;
    int stall_cnt  = 0;
    int done_cnt   = 0;
    int cyc        = 0;
    int last_hs_cyc = -100;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Window whose bottom-right pixel is (y,x) in a frame of width w, read from pix_mem.
    function automatic logic [71:0] model_win(input int w, input int y, input int x);
        logic [71:0] v;
        v = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                v[8*(3*r+c) +: 8] = pix_mem[(y-2+r)*w + (x-2+c)];
        return v;
    endfunction

    task automatic push_frame();
        for (int y = 2; y < 4; y++)
            for (int x = 2; x < 4; x++)
                sb.push_back(model_win(4, y, x));
    endtask

    // Downstream ready generator.
    initial begin
        win_ready = 1'b1;
        forever begin
            @(negedge clk);
            case (wr_mode)
                1: begin
                    if (stall_left > 0 && win_valid) begin
                        win_ready = 1'b0;
                        stall_left--;
                    end else begin
                        win_ready = 1'b1;
                    end
                end
                2:       win_ready = 1'($urandom_range(1));
                default: win_ready = 1'b1;
            endcase
        end
    end

    // Monitor: samples well after the drivers settle and before the next rising edge.
    initial begin
        logic        prev_stall;
        logic [71:0] prev_win;
        logic [71:0] exp;
        prev_stall = 1'b0;
        prev_win   = '0;
        forever begin
            @(negedge clk);
            #3;
            cyc++;
            if (prev_stall && !rst) begin
                check("stall win_valid held", win_valid, 1);
                check("stall win_out stable", win_out, prev_win);
            end
            if (win_valid && !win_ready) begin
                check("stall pix_ready low", pix_ready, 0);
                stall_cnt++;
            end
            if (win_valid && win_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected window", win_out, 'x);
                end else begin
                    exp = sb.pop_front();
                    check("window contents", win_out, exp);
                end
                last_hs_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                check("done latency", 72'(cyc - last_hs_cyc), 1);
                check("pix_ready in DONE", pix_ready, 0);
            end
            prev_stall = win_valid && !win_ready;
            prev_win   = win_out;
        end
    end

    task automatic send_frame(input bit gaps, input bit hold_go, input int n_stop);
        int i;
        int budget;
        i = 0;
        budget = 0;
        push_frame();
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = hold_go;
        while (i < n_stop && budget < 2000) begin
            pix_in    = pix_mem[i];
            pix_valid = gaps ? 1'($urandom_range(1)) : 1'b1;
            #1;
            check("busy during frame", busy, 1);
            if (pix_valid && pix_ready) i++;
            budget++;
            @(negedge clk);
        end
        if (budget >= 2000) check("pixel acceptance timeout", 72'(i), 72'(n_stop));
        go = 1'b0;
    endtask

    task automatic finish_frame(input int d0);
        int t;
        t = 0;
        while (done_cnt == d0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        repeat (5) @(negedge clk);
        #1;
        check("done pulse count", 72'(done_cnt), 72'(d0 + 1));
        check("busy after frame", busy, 0);
        check("windows outstanding", 72'(sb.size()), 0);
        pix_valid = 1'b0;
    endtask

    initial begin
        int d0;
        rst = 1'b1; go = 1'b0; pix_valid = 1'b0; pix_in = '0;
        go5 = 1'b0; pv5 = 1'b0; pix5 = '0;

        repeat (2) @(negedge clk);
        #1;
        check("reset pix_ready", pix_ready, 0);
        check("reset win_valid", win_valid, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset win_out", win_out, 0);
        rst = 1'b0;

        // Basic raster order, continuous flow.
        for (int i = 0; i < 16; i++) pix_mem[i] = 8'(i);
        d0 = done_cnt;
        send_frame(1'b0, 1'b0, 16);
        finish_frame(d0);

        // Backpressure on the first window.
        wr_mode = 1; stall_left = 5; stall_cnt = 0;
        d0 = done_cnt;
        send_frame(1'b0, 1'b0, 16);
        finish_frame(d0);
        check("stall cycles seen", 72'(stall_cnt), 5);
        wr_mode = 0;

        // pix_valid while IDLE is not accepted.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            pix_valid = 1'b1;
            #1;
            check("idle pix_ready", pix_ready, 0);
            check("idle busy", busy, 0);
        end

        // Source gaps with go held high through RUN.
        d0 = done_cnt;
        send_frame(1'b1, 1'b1, 16);
        finish_frame(d0);

        // Random pixels, random gaps, random downstream ready.
        for (int i = 0; i < 16; i++) pix_mem[i] = 8'($urandom);
        wr_mode = 2;
        d0 = done_cnt;
        send_frame(1'b1, 1'b0, 16);
        finish_frame(d0);
        wr_mode = 0;

        // Reset mid-frame after pixel 9.
        for (int i = 0; i < 16; i++) pix_mem[i] = 8'(i);
        d0 = done_cnt;
        send_frame(1'b0, 1'b0, 10);
        pix_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("abort pix_ready", pix_ready, 0);
        check("abort win_valid", win_valid, 0);
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort win_out", win_out, 0);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        repeat (5) @(negedge clk);
        check("no done after abort", 72'(done_cnt), 72'(d0));

        // Fresh frame after abort.
        for (int i = 0; i < 16; i++) pix_mem[i] = 8'(100 + i);
        d0 = done_cnt;
        send_frame(1'b0, 1'b0, 16);
        finish_frame(d0);

        // 5x3 instance: one window per cycle, one cycle after each completing pixel.
        begin
            int  idx, prev_idx, nwin, first_k, last_k, nd;
            bit  prev_acc, exp_v;
            idx = 0; prev_idx = 0; nwin = 0; first_k = -1; last_k = -1; nd = 0;
            prev_acc = 1'b0;
            for (int i = 0; i < 15; i++) pix_mem[i] = 8'(i);
            @(negedge clk);
            go5 = 1'b1;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                go5  = 1'b0;
                pix5 = pix_mem[idx];
                pv5  = (idx < 15);
                #3;
                exp_v = prev_acc && (prev_idx % 5 >= 2) && (prev_idx / 5 >= 2);
                check("w5 valid timing", wv5, 72'(exp_v));
                if (wv5) begin
                    nwin++;
                    if (first_k < 0) first_k = k;
                    last_k = k;
                    if (exp_v) check("w5 window", w5, model_win(5, prev_idx / 5, prev_idx % 5));
                end
                if (done5) nd++;
                if (k == 2) check("w5 busy", busy5, 1);
                prev_acc = pv5 && pr5;
                prev_idx = idx;
                if (prev_acc) idx++;
            end
            pv5 = 1'b0;
            check("w5 pixels accepted", 72'(idx), 15);
            check("w5 window count", 72'(nwin), 3);
            check("w5 back-to-back", 72'(last_k - first_k), 2);
            check("w5 done count", 72'(nd), 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
- Upstream stage of the convolution core.
- Accepts a raster-order stream of 8-bit pixels.
- Uses two line buffers plus a 3x3 shift register to present one complete 3x3 neighbourhood per output beat to the MAC/scale stage.
- Produces only "valid" windows, with no padding. For an IMG_W x IMG_H frame that gives (IMG_W-2) x (IMG_H-2) windows.
- Both sides use valid/ready handshakes, so downstream stalls propagate back to the pixel source.

Parameters:
- IMG_W, 256: pixels per row, minimum 3.
- IMG_H, 256: rows per frame, minimum 3.
- PIX_W, 8: bits per pixel.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: asynchronous active-high reset.
- go, input, 1: start-of-frame request; sampled only in IDLE.
- pix_in, input, PIX_W: input pixel.
- pix_valid, input, 1: pix_in is valid.
- pix_ready, output, 1: block accepts pix_in this cycle.
- win_out, output, 9*PIX_W: 3x3 window. Bits [PIX_W*(3*r+c) +: PIX_W] hold the pixel at row r, column c, with r=0 the top row and c=0 the left column.
- win_valid, output, 1: win_out holds a window.
- win_ready, input, 1: downstream accepts win_out.
- busy, output, 1: frame in progress.
- done, output, 1: single-cycle pulse after the last window is accepted.

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE; col=0; row=0.
  - win_valid=0, pix_ready=0, busy=0, done=0, win_out=0.
  - Line-buffer RAM contents are not cleared. Fill gating makes them irrelevant.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - pix_ready=0.
  - go=1 -> RUN; col, row cleared.
- RUN:
  - pix_ready = !win_valid || win_ready.
  - A pixel is accepted when pix_valid && pix_ready at a rising edge.
- On each acceptance of pixel (row y, col x):
  - The window shifts left by one column.
  - The new right column is {lb1[x], lb0[x], pix_in}, where lb1 holds row y-2 and lb0 holds row y-1.
  - Then lb1[x] <= lb0[x] and lb0[x] <= pix_in.
  - col increments and wraps to 0 at IMG_W-1. On that wrap, row increments.
- win_valid:
  - Set on the accepting edge when y>=2 and x>=2.
  - Latency is one cycle: the window is visible the cycle after the pixel that completes it.
  - Cleared on an edge where win_valid && win_ready and no new window is loaded.
  - Accepting a completing pixel while the current window is being handed off keeps win_valid=1 with the new contents. This gives back-to-back throughput of one window per cycle.
- Stall:
  - win_valid && !win_ready forces pix_ready=0.
  - win_out is held stable until accepted.
- After accepting the last pixel (y=IMG_H-1, x=IMG_W-1) -> DRAIN.
- DRAIN:
  - pix_ready=0.
  - Waits until win_valid && win_ready -> DONE.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
- busy=1 in RUN and DRAIN.
- Boundaries:
  - Row-edge windows (x<2) are never emitted, so no window spans two rows.
  - go is ignored outside IDLE.
  - pix_valid is ignored outside RUN.
  - Reset mid-frame aborts with no done pulse. The next frame after go is fully correct.
- Arithmetic:
  - Counters are unsigned, $clog2(IMG_W) and $clog2(IMG_H) bits wide.
  - No pixel arithmetic is performed in this block.

Test Plan:
- Basic window order: IMG_W=4, IMG_H=4, pixels 0..15, win_ready=1, pix_valid=1 -> exactly 4 windows.
  - First window = {0,1,2,4,5,6,8,9,10}.
  - Last window = {5,6,7,9,10,11,13,14,15}.
  - done pulses once, one cycle after the 4th handshake.
- Throughput and latency: IMG_W=5, IMG_H=3, continuous input -> 3 windows on consecutive cycles, each asserted the cycle after pixels 12, 13 and 14 are accepted.
- Backpressure: IMG_W=4, IMG_H=4, win_ready held 0 for 5 cycles while the 1st window is valid -> pix_ready=0, win_out stable at {0,1,2,4,5,6,8,9,10}. On release, the remaining windows arrive in order with none lost or duplicated.
- Source gaps: random pix_valid at 50% duty -> window sequence identical to the first scenario; busy=1 throughout.
- Reset mid-frame: rst pulsed after pixel 9 -> all outputs 0 asynchronously, no done. A new go followed by pixels 100..115 -> first window = {100,101,102,104,105,106,108,109,110}.
- Ignored inputs: go asserted during RUN, pix_valid during IDLE and DONE -> no state change, no acceptance (pix_ready=0 in those states).
